// File: rtl/datamem_arbiter_pkg.sv
// rtl/datamem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package datamem_arbiter_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/datamem_arbiter_if.sv
// rtl/datamem_arbiter_if.sv - single-port data memory bus between arbiter and memory
interface datamem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/datamem_arbiter_pick.sv
// rtl/datamem_arbiter_pick.sv - dm_arb_pick: two-requester round-robin winner select with debug lock
module dm_arb_pick
    import datamem_arbiter_pkg::*;
(
    input  logic       core_req,
    input  logic       dbg_req,
    input  logic [1:0] last_owner,
    input  logic       locked,
    output logic [1:0] grant
);

    always_comb begin
        grant = OWN_NONE;
        if (locked) begin
            if (dbg_req) grant = OWN_DBG;
        end else if (core_req && dbg_req) begin
            grant = (last_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end else if (core_req) begin
            grant = OWN_CORE;
        end else if (dbg_req) begin
            grant = OWN_DBG;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - shares the data memory between core and debug with issue/wait/resp sequencing
module datamem_arbiter
    import datamem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MEM_LAT  = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [AW-1:0]       core_addr,
    input  logic [DW-1:0]       core_wdata,
    output logic                core_ack,
    output logic [DW-1:0]       core_rdata,
    output logic                core_stall,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [DW-1:0]       dbg_wdata,
    input  logic                dbg_lock,
    output logic                dbg_ack,
    output logic [DW-1:0]       dbg_rdata,
    datamem_arbiter_if.master   mem,
    output logic [1:0]          owner
);

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_owner_q, last_owner_d;
    logic          locked_q, locked_d;
    logic [3:0]    lock_cnt_q, lock_cnt_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [1:0]    grant;
    logic [3:0]    lock_nxt;

    // A lock with no pending debug request is dropped in IDLE, so arbitration sees it unlocked.
    dm_arb_pick u_pick (
        .core_req   (core_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner_q),
        .locked     (locked_q & dbg_req),
        .grant      (grant)
    );

    assign lock_nxt = lock_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        locked_d     = locked_q;
        lock_cnt_d   = lock_cnt_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (locked_q && !dbg_req) begin
                    locked_d   = 1'b0;
                    lock_cnt_d = 4'd0;
                end
                if (grant != OWN_NONE) begin
                    owner_d  = grant;
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (grant == OWN_CORE) begin
                        mem_we_d    = core_we;
                        mem_addr_d  = core_addr;
                        mem_wdata_d = core_wdata;
                    end else begin
                        mem_we_d    = dbg_we;
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 3'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (owner_q == OWN_CORE) core_rdata_d = mem.mem_rdata;
                    else                     dbg_rdata_d  = mem.mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                owner_d      = OWN_NONE;
                state_d      = IDLE;
                // Lock count tallies completed locked accesses; hitting MAX_LOCK hands the bus back.
                if (owner_q == OWN_DBG) begin
                    if (dbg_lock && (lock_nxt < 4'(MAX_LOCK))) begin
                        locked_d   = 1'b1;
                        lock_cnt_d = lock_nxt;
                    end else begin
                        locked_d   = 1'b0;
                        lock_cnt_d = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            last_owner_q <= OWN_DBG;
            locked_q     <= 1'b0;
            lock_cnt_q   <= 4'd0;
            cnt_q        <= 3'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign core_ack      = (state_q == RESP) && (owner_q == OWN_CORE);
    assign dbg_ack       = (state_q == RESP) && (owner_q == OWN_DBG);
    assign core_stall    = core_req & ~core_ack;
    assign core_rdata    = core_rdata_q;
    assign dbg_rdata     = dbg_rdata_q;
    assign owner         = owner_q;
    assign mem.mem_en    = mem_en_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Shares the single-port data memory between the processor core's load/store path and a debug/DMA requester. It sequences each access through issue, latency-wait and response phases. Requesters see a req/ack handshake, and the core also gets a stall indication. The block sits between the core's data-memory address/data muxing and the data_memory instance. Arbitration is round-robin, with an optional bounded lock that lets the debug port perform atomic read-modify-write sequences.

## Interface
- AW, 8, address width
- DW, 8, data width
- MEM_LAT, 1, cycles from mem_en cycle to valid mem_rdata (legal 1..7)
- MAX_LOCK, 4, max consecutive locked debug accesses (legal 1..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  core access request, held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  DW  read data, valid with core_ack, held until next core access
- core_stall  out  1  core_req & ~core_ack
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug request, same rules as core
- dbg_lock  in  1  request to keep ownership after this access
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DW  as core_rdata
- mem_en  out  1  memory strobe, one cycle per access
- mem_we  out  1  write enable, valid with mem_en
- mem_addr  out  AW  address, valid with mem_en
- mem_wdata  out  DW  write data, valid with mem_en
- mem_rdata  in  DW  memory read data
- owner  out  2  00 none, 01 core, 10 debug

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Arbitrate on the current req inputs.
  - If a grant is made, latch owner, we, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** drive mem_en=1 with the latched fields. Load the wait counter with MEM_LAT. Go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - On the last cycle (counter=1), capture mem_rdata into the owner's rdata register. Writes capture as well; the value is don't-care.
  - Go to RESP.
- **RESP:** pulse the owner's ack, update last_owner, evaluate the lock, then go to IDLE. RESP never arbitrates.
- **Round-robin arbitration:**
  - A single requester always wins.
  - When both request, the winner is the one that is not last_owner.
- **Lock:**
  - If dbg_lock=1 during a debug RESP, set locked and increment lock_cnt.
  - While locked, IDLE grants debug only, and core waits even if it is alone.
  - Lock release happens when lock_cnt reaches MAX_LOCK, when a debug RESP has dbg_lock=0, or when IDLE sees dbg_req=0. The last case releases and arbitrates normally in the same cycle.
  - lock_cnt clears on release.
- **Protocol rules:**
  - Request fields must be stable while req=1 and before ack.
  - A requester may present a new request in the cycle after ack.
  - If req drops before ack, the access still completes and ack still pulses.
- **Reset values:**
  - Outputs: all 0, including owner=00 and both rdata registers.
  - Internal: state=IDLE, last_owner=debug (so core wins the first tie), locked=0, lock_cnt=0.
- **Reset mid-access:** the FSM returns to IDLE immediately. If mem_en had already pulsed, a write may have committed. No ack is issued.

## Timing
- Request sampled in IDLE at cycle t: ISSUE at t+1, WAIT over t+2..t+1+MEM_LAT, ack at t+MEM_LAT+2.
- With MEM_LAT=1, ack arrives at t+3.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- owner is registered. It is valid from ISSUE through RESP and reads 00 in IDLE.
- core_stall is combinational from core_req and core_ack.
- mem_* outputs are registered. mem_addr, mem_we and mem_wdata hold their values outside ISSUE. mem_en=0 outside ISSUE.

## Structure
- **Shared package:**
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner encodings (OWN_NONE=2'b00, OWN_CORE=2'b01, OWN_DBG=2'b10)
  - default AW/DW constants
- **One sub-module, dm_arb_pick:** combinational winner select from core_req, dbg_req, last_owner and locked. It is reused by any future resource arbiter.

## Test plan
- Core-only read of addr 0x10 (memory=0x5A), MEM_LAT=1 -> mem_en at t+1, core_ack and core_rdata=0x5A at t+3, core_stall high t..t+2.
- Simultaneous core and debug requests after reset -> core granted first (owner=01), debug second. Alternation continues while both hold requests.
- Debug locked RMW with dbg_lock=1 for 2 accesses while core_req=1 -> both debug accesses complete before core. Core granted in the IDLE after the 2nd debug ack.
- dbg_lock held with MAX_LOCK=4 and core waiting -> exactly 4 debug accesses, then core granted.
- Debug write 0xC3 to 0x20, then core read of 0x20 -> core_rdata=0xC3.
- rst asserted during WAIT of a core read -> outputs 0 immediately, no core_ack. A fresh request after reset completes with normal latency.
